// File: rtl/bus_arbiter.sv
// bus_arbiter
// Lets up to N_MASTERS bus masters share the single slave side of the system
// bus. Only one transaction is granted at a time, and it runs until the slave
// drops s_stall. Arbitration is round-robin, or fixed priority with the lowest
// index winning.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   m_address/m_read/m_write/m_data_wr/m_mask
//                     packed per-master request buses (slice i = master i)
//   m_stall           per-master stall, combinational
//   m_data_rd(_2)     slave read data broadcast to every master
//   m_interrupt       slave interrupt vector broadcast to every master
//   s_*               slave-side bus, driven from the granted master
//   grant_valid       a transaction is in flight (state BUSY)
//   grant_idx         index of the granted master
module bus_arbiter #(
    parameter int N_MASTERS      = 3,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_MASTERS*32-1:0]  m_address,
    input  logic [N_MASTERS-1:0]     m_read,
    input  logic [N_MASTERS-1:0]     m_write,
    input  logic [N_MASTERS*32-1:0]  m_data_wr,
    input  logic [N_MASTERS*4-1:0]   m_mask,
    output logic [N_MASTERS-1:0]     m_stall,
    output logic [31:0]              m_data_rd,
    output logic [31:0]              m_data_rd_2,
    output logic [5:0]               m_interrupt,
    output logic [31:0]              s_address,
    output logic                     s_read,
    output logic                     s_write,
    output logic [31:0]              s_data_wr,
    output logic [3:0]               s_mask,
    input  logic                     s_stall,
    input  logic [31:0]              s_data_rd,
    input  logic [31:0]              s_data_rd_2,
    input  logic [5:0]               s_interrupt,
    output logic                     grant_valid,
    output logic [2:0]               grant_idx
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_reg, state_next;
    logic [2:0] grant_idx_reg, grant_idx_next;
    logic [2:0] last_idx_reg, last_idx_next;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] grant_oh;
    logic                 granted_req;
    logic [2:0]           winner;

    logic [31:0] addr_arr [N_MASTERS];
    logic [31:0] wdata_arr[N_MASTERS];
    logic [3:0]  mask_arr [N_MASTERS];

    assign req = m_read | m_write;

    // Unpack the per-master buses and build a one-hot view of the grant
    // register so the muxes below only ever index with loop constants.
    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
            assign addr_arr[gi]  = m_address[gi*32 +: 32];
            assign wdata_arr[gi] = m_data_wr[gi*32 +: 32];
            assign mask_arr[gi]  = m_mask[gi*4 +: 4];
            assign grant_oh[gi]  = (grant_idx_reg == 3'(gi));
            // Stall every requester except the granted one in its completion cycle.
            assign m_stall[gi]   = req[gi] &
                                   ~((state_reg == BUSY) & grant_oh[gi] & ~s_stall);
        end
    endgenerate

    assign granted_req = |(req & grant_oh);

    // Winner selection. Round-robin rotates the doubled request vector so the
    // search starts at last_idx+1, finds the lowest set bit, then adds the
    // rotation back modulo N_MASTERS. The sum stays below 2*N_MASTERS, so a
    // single conditional subtraction covers the wrap.
    logic [2*N_MASTERS-1:0] req_rot;
    logic [3:0]             rr_base, rr_sum;
    logic [2:0]             rr_off, fp_idx;

    always_comb begin
        rr_base = {1'b0, last_idx_reg} + 4'd1;
        req_rot = {req, req} >> rr_base;
        rr_off  = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (req_rot[k]) rr_off = 3'(k);
        end
        rr_sum = rr_base + {1'b0, rr_off};
        if (rr_sum >= 4'(N_MASTERS)) rr_sum = rr_sum - 4'(N_MASTERS);

        fp_idx = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (req[k]) fp_idx = 3'(k);
        end

        winner = (FIXED_PRIORITY != 0) ? fp_idx : rr_sum[2:0];
    end

    // Next-state logic. A granted master that drops its request aborts the
    // transaction and is treated like a completion for round-robin purposes.
    always_comb begin
        state_next     = state_reg;
        grant_idx_next = grant_idx_reg;
        last_idx_next  = last_idx_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next     = BUSY;
                    grant_idx_next = winner;
                end
            end
            BUSY: begin
                if (!granted_req || !s_stall) begin
                    state_next    = IDLE;
                    last_idx_next = grant_idx_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_idx_reg <= '0;
            last_idx_reg  <= 3'(N_MASTERS - 1);
        end else begin
            state_reg     <= state_next;
            grant_idx_reg <= grant_idx_next;
            last_idx_reg  <= last_idx_next;
        end
    end

    // Slave-side mux. It depends only on registered state and the master
    // inputs, so s_stall never reaches s_read/s_write combinationally. An
    // aborting master has read and write low, which clears them here as well.
    always_comb begin
        s_address = '0;
        s_data_wr = '0;
        s_mask    = '0;
        s_read    = 1'b0;
        s_write   = 1'b0;
        if (state_reg == BUSY) begin
            for (int k = 0; k < N_MASTERS; k++) begin
                if (grant_oh[k]) begin
                    s_address = addr_arr[k];
                    s_data_wr = wdata_arr[k];
                    s_mask    = mask_arr[k];
                    s_read    = m_read[k];
                    s_write   = m_write[k];
                end
            end
        end
    end

    assign m_data_rd   = s_data_rd;
    assign m_data_rd_2 = s_data_rd_2;
    assign m_interrupt = s_interrupt;
    assign grant_valid = (state_reg == BUSY);
    assign grant_idx   = grant_idx_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: a round-robin and a fixed-priority instance share
// one set of stimulus, and sel_fp picks which one is being checked. Expected
// completions are queued when a request is driven and are popped by a
// negedge monitor whenever the checked instance finishes a transaction.
module tb_bus_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Stimulus is kept per master and packed onto the DUT buses.
    logic [31:0] addr_q [N];
    logic [31:0] wdata_q[N];
    logic [3:0]  mask_q [N];
    logic        rd_q   [N];
    logic        wr_q   [N];

    logic [N*32-1:0] m_address, m_data_wr;
    logic [N*4-1:0]  m_mask;
    logic [N-1:0]    m_read, m_write;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign m_address[gi*32 +: 32] = addr_q[gi];
            assign m_data_wr[gi*32 +: 32] = wdata_q[gi];
            assign m_mask[gi*4 +: 4]      = mask_q[gi];
            assign m_read[gi]             = rd_q[gi];
            assign m_write[gi]            = wr_q[gi];
        end
    endgenerate

    logic        s_stall;
    logic [31:0] s_data_rd, s_data_rd_2;
    logic [5:0]  s_interrupt;

    logic [N-1:0] rr_m_stall, fp_m_stall;
    logic [31:0]  rr_m_data_rd, fp_m_data_rd, rr_m_data_rd_2, fp_m_data_rd_2;
    logic [5:0]   rr_m_interrupt, fp_m_interrupt;
    logic [31:0]  rr_s_address, fp_s_address, rr_s_data_wr, fp_s_data_wr;
    logic         rr_s_read, fp_s_read, rr_s_write, fp_s_write;
    logic [3:0]   rr_s_mask, fp_s_mask;
    logic         rr_grant_valid, fp_grant_valid;
    logic [2:0]   rr_grant_idx, fp_grant_idx;

    bus_arbiter #(.N_MASTERS(N), .FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_data_wr(m_data_wr), .m_mask(m_mask),
        .m_stall(rr_m_stall), .m_data_rd(rr_m_data_rd), .m_data_rd_2(rr_m_data_rd_2),
        .m_interrupt(rr_m_interrupt),
        .s_address(rr_s_address), .s_read(rr_s_read), .s_write(rr_s_write),
        .s_data_wr(rr_s_data_wr), .s_mask(rr_s_mask),
        .s_stall(s_stall), .s_data_rd(s_data_rd), .s_data_rd_2(s_data_rd_2),
        .s_interrupt(s_interrupt),
        .grant_valid(rr_grant_valid), .grant_idx(rr_grant_idx)
    );

    bus_arbiter #(.N_MASTERS(N), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst(rst),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_data_wr(m_data_wr), .m_mask(m_mask),
        .m_stall(fp_m_stall), .m_data_rd(fp_m_data_rd), .m_data_rd_2(fp_m_data_rd_2),
        .m_interrupt(fp_m_interrupt),
        .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
        .s_data_wr(fp_s_data_wr), .s_mask(fp_s_mask),
        .s_stall(s_stall), .s_data_rd(s_data_rd), .s_data_rd_2(s_data_rd_2),
        .s_interrupt(s_interrupt),
        .grant_valid(fp_grant_valid), .grant_idx(fp_grant_idx)
    );

    // View of whichever instance is under test.
    logic         sel_fp;
    logic [N-1:0] a_m_stall;
    logic [31:0]  a_m_data_rd, a_m_data_rd_2, a_s_address, a_s_data_wr;
    logic [5:0]   a_m_interrupt;
    logic         a_s_read, a_s_write, a_grant_valid;
    logic [3:0]   a_s_mask;
    logic [2:0]   a_grant_idx;

    always_comb begin
        a_m_stall     = sel_fp ? fp_m_stall     : rr_m_stall;
        a_m_data_rd   = sel_fp ? fp_m_data_rd   : rr_m_data_rd;
        a_m_data_rd_2 = sel_fp ? fp_m_data_rd_2 : rr_m_data_rd_2;
        a_m_interrupt = sel_fp ? fp_m_interrupt : rr_m_interrupt;
        a_s_address   = sel_fp ? fp_s_address   : rr_s_address;
        a_s_data_wr   = sel_fp ? fp_s_data_wr   : rr_s_data_wr;
        a_s_read      = sel_fp ? fp_s_read      : rr_s_read;
        a_s_write     = sel_fp ? fp_s_write     : rr_s_write;
        a_s_mask      = sel_fp ? fp_s_mask      : rr_s_mask;
        a_grant_valid = sel_fp ? fp_grant_valid : rr_grant_valid;
        a_grant_idx   = sel_fp ? fp_grant_idx   : rr_grant_idx;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(logic [N-1:0] v, int i);
        logic r;
        r = 1'b0;
        for (int k = 0; k < N; k++) if (k == i) r = v[k];
        return r;
    endfunction

    // Scoreboard of expected completions.
    typedef struct {
        logic [2:0]  idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        rd;
        logic        wr;
        logic [31:0] rdata;
        logic [31:0] rdata2;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(int i);
        exp_t e;
        e.idx    = 3'(i);
        e.addr   = addr_q[i];
        e.wdata  = wdata_q[i];
        e.mask   = mask_q[i];
        e.rd     = rd_q[i];
        e.wr     = wr_q[i];
        e.rdata  = s_data_rd;
        e.rdata2 = s_data_rd_2;
        sb.push_back(e);
    endtask

    task automatic set_master(int i, logic rd, logic wr, logic [31:0] a,
                              logic [31:0] d, logic [3:0] mk);
        rd_q[i]    = rd;
        wr_q[i]    = wr;
        addr_q[i]  = a;
        wdata_q[i] = d;
        mask_q[i]  = mk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_timeout: %0d completions still pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic irq_chk(logic [5:0] val);
        s_interrupt = val;
        #1;
        chk("m_interrupt", 32'(a_m_interrupt), 32'(val));
    endtask

    // Cycle counter and completion spacing for the continuous round-robin run.
    int   cyc = 0;
    int   last_done_cyc;
    logic spacing_en;
    logic first_done;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0] req_tb;
    logic         mon_done;
    exp_t         mon_e;

    always_comb begin
        for (int i = 0; i < N; i++) req_tb[i] = rd_q[i] | wr_q[i];
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_tb[i] && !(a_grant_valid && a_grant_idx == 3'(i)))
                    chk("stall_waiting", 32'(a_m_stall[i]), 32'd1);
            end
            mon_done = 1'b0;
            for (int i = 0; i < N; i++)
                if (a_grant_valid && !s_stall && a_grant_idx == 3'(i) && req_tb[i]) mon_done = 1'b1;
            if (mon_done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: master %0d granted, none expected", a_grant_idx);
                end else begin
                    mon_e = sb.pop_front();
                    chk("grant_idx",   32'(a_grant_idx), 32'(mon_e.idx));
                    chk("s_address",   a_s_address, mon_e.addr);
                    chk("s_read",      32'(a_s_read), 32'(mon_e.rd));
                    chk("s_write",     32'(a_s_write), 32'(mon_e.wr));
                    chk("s_data_wr",   a_s_data_wr, mon_e.wdata);
                    chk("s_mask",      32'(a_s_mask), 32'(mon_e.mask));
                    chk("m_data_rd",   a_m_data_rd, mon_e.rdata);
                    chk("m_data_rd_2", a_m_data_rd_2, mon_e.rdata2);
                    chk("done_stall",  32'(bit_of(a_m_stall, int'(mon_e.idx))), 32'd0);
                    if (spacing_en && !first_done)
                        chk("spacing", 32'(cyc - last_done_cyc), 32'd2);
                    first_done    = 1'b0;
                    last_done_cyc = cyc;
                    $display("txn: master %0d addr 0x%08h rd %0b wr %0b done at cycle %0d",
                             a_grant_idx, a_s_address, a_s_read, a_s_write, cyc);
                end
            end
        end
    end

    typedef struct {
        int          m;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          stall;
        logic [31:0] rdata;
        logic [5:0]  irq;
    } vec_t;

    vec_t vt[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,        4'h0,    0, 32'h1234_5678, 6'b000001};
        vt[1] = '{0, 1'b0, 1'b1, 32'h0300_0000, 32'h0000_00A5, 4'b0001, 3, 32'h0,         6'b000001};
        vt[2] = '{2, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'hF,    1, 32'hDEAD_BEEF, 6'b100010};
        vt[3] = '{2, 1'b1, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 4'b1010, 0, 32'h0F0F_0F0F, 6'b010100};

        sel_fp      = 1'b0;
        spacing_en  = 1'b0;
        first_done  = 1'b1;
        last_done_cyc = 0;
        s_stall     = 1'b0;
        s_data_rd   = '0;
        s_data_rd_2 = '0;
        s_interrupt = '0;
        for (int i = 0; i < N; i++) set_master(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_grant_valid", 32'(a_grant_valid), 32'd0);
        chk("rst_grant_idx",   32'(a_grant_idx), 32'd0);
        chk("rst_s_read",      32'(a_s_read), 32'd0);
        chk("rst_s_write",     32'(a_s_write), 32'd0);
        chk("rst_s_address",   a_s_address, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single-master transactions, with and without slave stalls.
        for (int v = 0; v < 4; v++) begin
            s_stall     = 1'b0;
            s_data_rd   = vt[v].rdata;
            s_data_rd_2 = ~vt[v].rdata;
            set_master(vt[v].m, vt[v].rd, vt[v].wr, vt[v].addr, vt[v].wdata, vt[v].mask);
            push_exp(vt[v].m);
            @(negedge clk);
            chk("idle_grant_valid", 32'(a_grant_valid), 32'd0);
            chk("idle_m_stall",     32'(bit_of(a_m_stall, vt[v].m)), 32'd1);
            chk("idle_s_read",      32'(a_s_read), 32'd0);
            chk("idle_s_write",     32'(a_s_write), 32'd0);
            chk("idle_s_address",   a_s_address, 32'd0);
            irq_chk(vt[v].irq);
            for (int k = 0; k <= vt[v].stall; k++) begin
                tick();
                s_stall = (k < vt[v].stall);
                @(negedge clk);
                chk("busy_grant_valid", 32'(a_grant_valid), 32'd1);
                chk("busy_grant_idx",   32'(a_grant_idx), 32'(vt[v].m));
                chk("busy_s_read",      32'(a_s_read), 32'(vt[v].rd));
                chk("busy_s_write",     32'(a_s_write), 32'(vt[v].wr));
                chk("busy_s_address",   a_s_address, vt[v].addr);
                chk("busy_s_data_wr",   a_s_data_wr, vt[v].wdata);
                chk("busy_s_mask",      32'(a_s_mask), 32'(vt[v].mask));
                chk("busy_m_stall",     32'(bit_of(a_m_stall, vt[v].m)), 32'(k < vt[v].stall));
                irq_chk(~vt[v].irq);
            end
            tick();
            set_master(vt[v].m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            s_stall = 1'b0;
            @(negedge clk);
            chk("after_grant_valid", 32'(a_grant_valid), 32'd0);
            tick();
        end
        chk("vec_sb_empty", 32'(sb.size()), 32'd0);

        // Three masters requesting continuously under round-robin.
        s_data_rd   = 32'hCAFE_0001;
        s_data_rd_2 = 32'hCAFE_0002;
        for (int i = 0; i < N; i++)
            set_master(i, i != 1, i == 1, 32'h1000 * (i + 1), 32'hD0 + i, 4'(i + 1));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_exp(i);
        spacing_en = 1'b1;
        first_done = 1'b1;
        wait_empty(40);
        spacing_en = 1'b0;
        for (int i = 0; i < N; i++) set_master(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();

        // Reset while master 1 holds a stalled write.
        s_stall = 1'b1;
        set_master(1, 1'b0, 1'b1, 32'h2000_0010, 32'h55, 4'hF);
        tick();
        @(negedge clk);
        chk("pre_rst_grant_valid", 32'(a_grant_valid), 32'd1);
        chk("pre_rst_grant_idx",   32'(a_grant_idx), 32'd1);
        chk("pre_rst_s_write",     32'(a_s_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_s_write",     32'(a_s_write), 32'd0);
        chk("rst_async_grant_valid", 32'(a_grant_valid), 32'd0);
        chk("rst_m_stall",           32'(bit_of(a_m_stall, 1)), 32'd1);
        tick();
        rst     = 1'b0;
        s_stall = 1'b0;
        set_master(0, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF);
        push_exp(0);
        push_exp(1);
        wait_empty(20);
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();

        // Fixed priority: master 2 waits until master 0 lets go.
        sel_fp = 1'b1;
        set_master(0, 1'b1, 1'b0, 32'h0000_A000, 32'h0, 4'hF);
        set_master(2, 1'b1, 1'b0, 32'h0000_C000, 32'h0, 4'hF);
        for (int r = 0; r < 3; r++) push_exp(0);
        wait_empty(30);
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        push_exp(2);
        wait_empty(10);
        set_master(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
